// File: rtl/simple_axi_pkg.sv
// Shared encodings for the simple AXI4 RAM slave: response codes, burst types,
// beat size and FSM/arbiter state types.
package simple_axi_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_e;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_e;

    localparam logic [2:0] SIZE_4B = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WDATA,
        ST_WRESP,
        ST_RDATA
    } state_e;

    typedef enum logic {
        PRIO_W = 1'b0,
        PRIO_R = 1'b1
    } prio_e;

    // Only 4-byte INCR bursts are served; anything else is answered with SLVERR.
    function automatic logic cfg_bad(input logic [2:0] size, input logic [1:0] burst);
        return (size != SIZE_4B) || (burst != BURST_INCR);
    endfunction

endpackage

// File: rtl/simple_axi_ram_slave_if.sv
// AXI4 memory-mapped bus between a master and the RAM slave (no IDs, no
// user/lock/cache/prot signals).
interface simple_axi_ram_slave_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) ();
    logic                    awvalid;
    logic                    awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;
    logic                    arvalid;
    logic                    arready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    rvalid;
    logic                    rready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;

    modport master (
        output awvalid, awaddr, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast, bready,
        output arvalid, araddr, arlen, arsize, arburst, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast
    );

    modport slave (
        input  awvalid, awaddr, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast, bready,
        input  arvalid, araddr, arlen, arsize, arburst, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast
    );
endinterface

// File: rtl/simple_axi_ram_slave_mem.sv
// Synchronous 1R/1W RAM with per-byte write enables and a registered read port
// that holds its value until the next read enable.
module simple_axi_ram_slave_mem #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_WORDS  = 1024,
    localparam int IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic                    i_clk,
    input  logic                    wr_en,
    input  logic [IDX_W-1:0]        wr_idx,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    input  logic                    rd_en,
    input  logic [IDX_W-1:0]        rd_idx,
    output logic [DATA_WIDTH-1:0]   rd_data
);

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    // NOTE: the array has no reset branch so it maps onto block RAM; contents survive i_rst.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            for (int b = 0; b < DATA_WIDTH / 8; b++) begin
                if (wr_strb[b]) mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
        if (rd_en) rd_data <= mem[rd_idx];
    end

endmodule

// File: rtl/simple_axi_ram_slave.sv
// AXI4 RAM slave: one transaction at a time, INCR bursts with byte strobes,
// round-robin AW/AR arbitration and per-beat address range checking.
module simple_axi_ram_slave
    import simple_axi_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h1000_0000,
    parameter int                    MEM_WORDS  = 1024
) (
    input logic                   i_clk,
    input logic                   i_rst,
    simple_axi_ram_slave_if.slave s_axi
);

    localparam int             WA      = ADDR_WIDTH - 2;
    localparam int             IDX_W   = $clog2(MEM_WORDS);
    localparam logic [WA-1:0]  BASE_W  = BASE_ADDR[ADDR_WIDTH-1:2];
    localparam logic [WA-1:0]  DEPTH_W = WA'(MEM_WORDS);

    state_e          state, state_nx;
    prio_e           rr_prio;
    logic [WA-1:0]   addr;       // word address of the next beat to write or read
    logic [7:0]      len, cnt;
    logic            cfg_err, w_err, r_err, r_last;
    logic            aw_hs, ar_hs, w_hs, r_hs, wr_en, rd_en;
    logic [WA-1:0]   rd_wa, rd_off, wr_off;
    logic            rd_in_range, wr_in_range;
    logic [DATA_WIDTH-1:0] mem_q;

    // Range checks are done on word addresses; the byte offset bits are ignored.
    assign rd_wa       = (state == ST_IDLE) ? s_axi.araddr[ADDR_WIDTH-1:2] : addr;
    assign rd_off      = rd_wa - BASE_W;
    assign rd_in_range = (rd_wa >= BASE_W) && (rd_off < DEPTH_W);
    assign wr_off      = addr - BASE_W;
    assign wr_in_range = (addr >= BASE_W) && (wr_off < DEPTH_W);

    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking (<=) in clocked blocks so every register samples pre-edge values.
        if (i_rst) state <= ST_IDLE;
        else       state <= state_nx;
    end

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        state_nx      = state;
        aw_hs         = 1'b0;
        ar_hs         = 1'b0;
        w_hs          = 1'b0;
        r_hs          = 1'b0;
        wr_en         = 1'b0;
        rd_en         = 1'b0;
        s_axi.awready = 1'b0;
        s_axi.arready = 1'b0;
        s_axi.wready  = 1'b0;
        s_axi.bvalid  = 1'b0;
        s_axi.rvalid  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                s_axi.awready = s_axi.awvalid & (~s_axi.arvalid | (rr_prio == PRIO_W));
                s_axi.arready = s_axi.arvalid & (~s_axi.awvalid | (rr_prio == PRIO_R));
                aw_hs         = s_axi.awready;
                ar_hs         = s_axi.arready;
                rd_en         = ar_hs;
                if (aw_hs)      state_nx = ST_WDATA;
                else if (ar_hs) state_nx = ST_RDATA;
            end
            ST_WDATA: begin
                s_axi.wready = 1'b1;
                w_hs         = s_axi.wvalid;
                wr_en        = w_hs & ~cfg_err & wr_in_range;
                if (w_hs && (s_axi.wlast || cnt == len)) state_nx = ST_WRESP;
            end
            ST_WRESP: begin
                s_axi.bvalid = 1'b1;
                if (s_axi.bready) state_nx = ST_IDLE;
            end
            ST_RDATA: begin
                s_axi.rvalid = 1'b1;
                r_hs         = s_axi.rready;
                // Fetch the next beat in the handshake cycle to sustain one beat per clock.
                rd_en        = r_hs & ~r_last;
                if (r_hs && r_last) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rr_prio <= PRIO_W;
            addr    <= '0;
            len     <= '0;
            cnt     <= '0;
            cfg_err <= 1'b0;
            w_err   <= 1'b0;
            r_err   <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            if (state == ST_IDLE && s_axi.awvalid && s_axi.arvalid)
                rr_prio <= (rr_prio == PRIO_W) ? PRIO_R : PRIO_W;
            if (aw_hs) begin
                addr    <= s_axi.awaddr[ADDR_WIDTH-1:2];
                len     <= s_axi.awlen;
                cnt     <= '0;
                cfg_err <= cfg_bad(s_axi.awsize, s_axi.awburst);
                w_err   <= cfg_bad(s_axi.awsize, s_axi.awburst);
            end
            if (ar_hs) begin
                addr    <= s_axi.araddr[ADDR_WIDTH-1:2] + 1'b1;
                len     <= s_axi.arlen;
                cnt     <= '0;
                cfg_err <= cfg_bad(s_axi.arsize, s_axi.arburst);
                r_err   <= cfg_bad(s_axi.arsize, s_axi.arburst) | ~rd_in_range;
                r_last  <= (s_axi.arlen == 8'd0);
            end
            if (w_hs) begin
                addr <= addr + 1'b1;
                cnt  <= cnt + 8'd1;
                // A dropped out-of-range beat or a misplaced wlast fails the whole burst.
                if ((s_axi.wlast != (cnt == len)) || !wr_in_range) w_err <= 1'b1;
            end
            if (r_hs && !r_last) begin
                addr   <= addr + 1'b1;
                cnt    <= cnt + 8'd1;
                r_err  <= cfg_err | ~rd_in_range;
                r_last <= (cnt + 8'd1 == len);
            end
            if (state == ST_WRESP && s_axi.bready) w_err <= 1'b0;
        end
    end

    // Response fields are qualified by their valid so they read as zero when idle.
    assign s_axi.bresp = (state == ST_WRESP && w_err) ? RESP_SLVERR : RESP_OKAY;
    assign s_axi.rresp = (state == ST_RDATA && r_err) ? RESP_SLVERR : RESP_OKAY;
    assign s_axi.rlast = (state == ST_RDATA) & r_last;
    assign s_axi.rdata = (state == ST_RDATA && !r_err) ? mem_q : '0;

    simple_axi_ram_slave_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_WORDS  (MEM_WORDS)
    ) u_mem (
        .i_clk   (i_clk),
        .wr_en   (wr_en),
        .wr_idx  (wr_off[IDX_W-1:0]),
        .wr_data (s_axi.wdata),
        .wr_strb (s_axi.wstrb),
        .rd_en   (rd_en),
        .rd_idx  (rd_off[IDX_W-1:0]),
        .rd_data (mem_q)
    );

endmodule

// File: tb/tb_simple_axi_ram_slave.sv
// Randomised self-checking bench for simple_axi_ram_slave against a word-array
// reference model of the RAM and its response rules.
module tb_simple_axi_ram_slave;

    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam int          WORDS = 1024;
    localparam int          BUDGET = 50;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] ref_mem [WORDS];
    logic [31:0] wbuf [256];
    logic [3:0]  sbuf [256];
    bit          prio_read = 1'b0;  // model of the arbiter: next contested grant goes to read

    simple_axi_ram_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    simple_axi_ram_slave #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .BASE_ADDR  (BASE),
        .MEM_WORDS  (WORDS)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .s_axi (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] beat_addr(input logic [31:0] a, input int i);
        return {a[31:2], 2'b00} + 32'(4 * i);
    endfunction

    function automatic bit in_range(input logic [31:0] ba);
        return (ba >= BASE) && (64'(ba) < 64'(BASE) + 64'(4 * WORDS));
    endfunction

    function automatic int widx(input logic [31:0] ba);
        return int'((ba - BASE) >> 2);
    endfunction

    function automatic logic [31:0] exp_rdata(input logic [31:0] ba, input bit bad);
        if (bad) return 32'h0;
        return ref_mem[widx(ba)];
    endfunction

    function automatic bit bad_cfg(input logic [2:0] sz, input logic [1:0] bu);
        return (sz != 3'b010) || (bu != 2'b01);
    endfunction

    task automatic wait_hs(input string tag, input int sel);
        bit r = 1'b0;
        int n = 0;
        do begin
            @(negedge clk);
            n++;
            case (sel)
                0:       r = bus.awready;
                1:       r = bus.wready;
                default: r = bus.arready;
            endcase
        end while (!r && n < BUDGET);
        check(tag, 32'(r), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic aw_phase(input logic [31:0] a, input int len, input logic [2:0] sz, input logic [1:0] bu);
        bus.awaddr = a; bus.awlen = 8'(len); bus.awsize = sz; bus.awburst = bu;
        bus.awvalid = 1'b1;
        wait_hs("aw_hs", 0);
        bus.awvalid = 1'b0;
    endtask

    // last_at > len means wlast is never raised; the slave then stops after len+1 beats.
    task automatic w_phase(input logic [31:0] a, input int len, input bit cfg, input int last_at,
                           output logic [1:0] exp_resp);
        int  n_beats = (last_at < len) ? last_at + 1 : len + 1;
        bit  err = cfg || (last_at != len);
        for (int i = 0; i < n_beats; i++) begin
            logic [31:0] ba = beat_addr(a, i);
            bus.wdata = wbuf[i]; bus.wstrb = sbuf[i]; bus.wlast = (i == last_at);
            bus.wvalid = 1'b1;
            wait_hs("w_hs", 1);
            if (!in_range(ba)) err = 1'b1;
            else if (!cfg) begin
                for (int b = 0; b < 4; b++)
                    if (sbuf[i][b]) ref_mem[widx(ba)][b*8 +: 8] = wbuf[i][b*8 +: 8];
            end
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        exp_resp = err ? 2'b10 : 2'b00;
    endtask

    task automatic b_phase(input string tag, input logic [1:0] exp_resp);
        bit r = 1'b0;
        int n = 0;
        logic [1:0] resp = 2'b00;
        bus.bready = 1'b1;
        do begin
            @(negedge clk);
            n++;
            r = bus.bvalid;
            resp = bus.bresp;
        end while (!r && n < BUDGET);
        check({tag, "_bvalid"}, 32'(r), 32'd1);
        check({tag, "_bresp"}, 32'(resp), 32'(exp_resp));
        @(posedge clk); #1;
        bus.bready = 1'b0;
    endtask

    task automatic do_write(input string tag, input logic [31:0] a, input int len,
                            input logic [2:0] sz, input logic [1:0] bu, input int last_at);
        logic [1:0] er;
        aw_phase(a, len, sz, bu);
        w_phase(a, len, bad_cfg(sz, bu), last_at, er);
        b_phase(tag, er);
    endtask

    // mode 0: rready always high; 1: random rready; 2: rready low for the first 3 valid cycles.
    task automatic r_phase(input logic [31:0] a, input int len, input bit cfg, input int mode, input bit b2b);
        int  beat = 0, cyc = 0, stalls = 0;
        bit  held = 1'b0;
        logic [31:0] hd = '0;
        logic [1:0]  hr = '0;
        logic        hl = 1'b0;
        bus.rready = (mode == 0);
        while (beat <= len && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            if (bus.rvalid) begin
                if (held) begin
                    check("r_hold_data", bus.rdata, hd);
                    check("r_hold_resp", 32'(bus.rresp), 32'(hr));
                    check("r_hold_last", 32'(bus.rlast), 32'(hl));
                end
                if (bus.rready) begin
                    logic [31:0] ba;
                    bit bad;
                    ba  = beat_addr(a, beat);
                    bad = cfg || !in_range(ba);
                    check("r_data", bus.rdata, exp_rdata(ba, bad));
                    check("r_resp", 32'(bus.rresp), bad ? 32'd2 : 32'd0);
                    check("r_last", 32'(bus.rlast), 32'(beat == len));
                    beat++;
                    held = 1'b0;
                end else begin
                    held = 1'b1; hd = bus.rdata; hr = bus.rresp; hl = bus.rlast;
                    stalls++;
                end
            end else begin
                if (held) check("r_hold_valid", 32'(bus.rvalid), 32'd1);
                if (b2b && beat > 0) check("r_b2b", 32'(bus.rvalid), 32'd1);
                held = 1'b0;
            end
            @(posedge clk); #1;
            case (mode)
                0:       bus.rready = 1'b1;
                1:       bus.rready = ($urandom_range(0, 3) != 0);
                default: bus.rready = (stalls >= 3);
            endcase
        end
        check("r_beats", 32'(beat), 32'(len + 1));
        bus.rready = 1'b0;
        @(negedge clk);
        check("r_drop", 32'(bus.rvalid), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_read(input logic [31:0] a, input int len, input logic [2:0] sz,
                           input logic [1:0] bu, input int mode, input bit b2b);
        bus.araddr = a; bus.arlen = 8'(len); bus.arsize = sz; bus.arburst = bu;
        bus.arvalid = 1'b1;
        wait_hs("ar_hs", 2);
        bus.arvalid = 1'b0;
        r_phase(a, len, bad_cfg(sz, bu), mode, b2b);
    endtask

    // AW and AR raised in the same cycle; the model predicts which one is granted.
    task automatic both_test(input int mode);
        bit exp_w = !prio_read;
        logic [1:0] er;
        logic [31:0] wa = BASE + 32'($urandom_range(0, WORDS - 1) * 4);
        logic [31:0] ra = BASE + 32'($urandom_range(0, WORDS - 1) * 4);
        bus.awaddr = wa; bus.awlen = 8'd0; bus.awsize = 3'b010; bus.awburst = 2'b01;
        bus.araddr = ra; bus.arlen = 8'd0; bus.arsize = 3'b010; bus.arburst = 2'b01;
        bus.awvalid = 1'b1; bus.arvalid = 1'b1;
        @(negedge clk);
        check("arb_awready", 32'(bus.awready), 32'(exp_w));
        check("arb_arready", 32'(bus.arready), 32'(!exp_w));
        @(posedge clk); #1;
        bus.awvalid = 1'b0; bus.arvalid = 1'b0;
        prio_read = !prio_read;
        if (exp_w) begin
            wbuf[0] = $urandom; sbuf[0] = 4'hF;
            w_phase(wa, 0, 1'b0, 0, er);
            b_phase("arb_w", er);
        end else begin
            r_phase(ra, 0, 1'b0, mode, 1'b0);
        end
    endtask

    task automatic fill_bufs(input int len, input bit rnd_strb);
        for (int i = 0; i <= len; i++) begin
            wbuf[i] = $urandom;
            sbuf[i] = rnd_strb ? 4'($urandom) : 4'hF;
        end
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  er;
        bus.awvalid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 0; bus.awburst = 0;
        bus.wvalid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 0; bus.bready = 0;
        bus.arvalid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 0; bus.arburst = 0;
        bus.rready = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_awready", 32'(bus.awready), 32'd0);
        check("rst_arready", 32'(bus.arready), 32'd0);
        check("rst_wready",  32'(bus.wready),  32'd0);
        check("rst_bvalid",  32'(bus.bvalid),  32'd0);
        check("rst_rvalid",  32'(bus.rvalid),  32'd0);
        check("rst_rlast",   32'(bus.rlast),   32'd0);
        check("rst_bresp",   32'(bus.bresp),   32'd0);
        check("rst_rresp",   32'(bus.rresp),   32'd0);
        check("rst_rdata",   bus.rdata,        32'd0);
        @(posedge clk); #1;

        // Initialise the whole RAM with four maximum-length bursts.
        for (int k = 0; k < 4; k++) begin
            fill_bufs(255, 1'b0);
            do_write("init", BASE + 32'(k * 1024), 255, 3'b010, 2'b01, 255);
        end

        // Single write then read back.
        wbuf[0] = 32'hCAFE_BABE; sbuf[0] = 4'hF;
        do_write("single", BASE, 0, 3'b010, 2'b01, 0);
        do_read(BASE, 0, 3'b010, 2'b01, 0, 1'b0);

        // Read outside the decoded window.
        do_read(32'h2000_0000, 0, 3'b010, 2'b01, 0, 1'b0);

        // Four-beat burst, read back at full rate.
        for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; end
        do_write("burst4", BASE + 32'h10, 3, 3'b010, 2'b01, 3);
        do_read(BASE + 32'h10, 3, 3'b010, 2'b01, 0, 1'b1);

        // Byte strobe merge.
        wbuf[0] = 32'hFFFF_FFFF; sbuf[0] = 4'hF;
        do_write("strb_full", BASE + 32'h40, 0, 3'b010, 2'b01, 0);
        wbuf[0] = 32'h0000_0012; sbuf[0] = 4'b0001;
        do_write("strb_byte", BASE + 32'h40, 0, 3'b010, 2'b01, 0);
        do_read(BASE + 32'h40, 0, 3'b010, 2'b01, 0, 1'b0);
        check("strb_merge_model", ref_mem[16], 32'hFFFF_FF12);

        // Contested AW/AR: write first, then read with a 3-cycle rready stall.
        both_test(0);
        both_test(2);
        both_test(1);
        both_test(1);

        // Configuration errors: bad size on write, FIXED burst and bad size on read.
        fill_bufs(1, 1'b0);
        do_write("cfg_size", BASE + 32'h80, 1, 3'b001, 2'b01, 1);
        do_read(BASE + 32'h80, 1, 3'b010, 2'b00, 0, 1'b0);
        do_read(BASE + 32'h80, 0, 3'b011, 2'b01, 0, 1'b0);

        // wlast early, and wlast never raised.
        fill_bufs(3, 1'b0);
        do_write("wlast_early", BASE + 32'h100, 3, 3'b010, 2'b01, 1);
        fill_bufs(2, 1'b0);
        do_write("wlast_never", BASE + 32'h120, 2, 3'b010, 2'b01, 99);
        do_read(BASE + 32'h100, 11, 3'b010, 2'b01, 1, 1'b0);

        // Zero strobes leave the word untouched with OKAY.
        wbuf[0] = $urandom; sbuf[0] = 4'h0;
        do_write("strb_zero", BASE + 32'h200, 0, 3'b010, 2'b01, 0);
        do_read(BASE + 32'h200, 0, 3'b010, 2'b01, 0, 1'b0);

        // Window boundaries, address wrap and unaligned start.
        fill_bufs(1, 1'b0);
        do_write("top_edge", BASE + 32'(4 * (WORDS - 1)), 1, 3'b010, 2'b01, 1);
        do_read(BASE + 32'(4 * (WORDS - 1)), 1, 3'b010, 2'b01, 0, 1'b1);
        do_read(BASE - 32'd4, 1, 3'b010, 2'b01, 0, 1'b1);
        do_read(32'hFFFF_FFFC, 1, 3'b010, 2'b01, 0, 1'b0);
        fill_bufs(1, 1'b1);
        do_write("unaligned", BASE + 32'h21, 1, 3'b010, 2'b01, 1);
        do_read(BASE + 32'h23, 1, 3'b010, 2'b01, 0, 1'b0);

        // Reset in the middle of a 4-beat write: only the first beat lands.
        fill_bufs(3, 1'b0);
        a = BASE + 32'h300;
        aw_phase(a, 3, 3'b010, 2'b01);
        bus.wdata = wbuf[0]; bus.wstrb = 4'hF; bus.wlast = 1'b0; bus.wvalid = 1'b1;
        wait_hs("w_hs", 1);
        ref_mem[widx(a)] = wbuf[0];
        bus.wvalid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        prio_read = 1'b0;
        check("mid_rst_wready",  32'(bus.wready),  32'd0);
        check("mid_rst_bvalid",  32'(bus.bvalid),  32'd0);
        check("mid_rst_rvalid",  32'(bus.rvalid),  32'd0);
        check("mid_rst_awready", 32'(bus.awready), 32'd0);
        check("mid_rst_arready", 32'(bus.arready), 32'd0);
        do_read(a, 1, 3'b010, 2'b01, 0, 1'b1);
        wbuf[0] = $urandom; sbuf[0] = 4'hF;
        do_write("after_rst", a + 32'd8, 0, 3'b010, 2'b01, 0);
        do_read(a + 32'd8, 0, 3'b010, 2'b01, 0, 1'b0);

        // Random traffic.
        for (int t = 0; t < 40; t++) begin
            int          len = $urandom_range(0, 7);
            logic [2:0]  sz  = ($urandom_range(0, 9) == 0) ? 3'b001 : 3'b010;
            logic [1:0]  bu  = ($urandom_range(0, 9) == 0) ? 2'b10 : 2'b01;
            int          la  = (len > 0 && $urandom_range(0, 7) == 0) ? len - 1 : len;
            a = BASE + 32'($urandom_range(0, WORDS + 6) * 4) + 32'($urandom_range(0, 3));
            fill_bufs(len, 1'b1);
            do_write("rnd", a, len, sz, bu, la);
            do_read(a, len, 3'b010, ($urandom_range(0, 9) == 0) ? 2'b00 : 2'b01, 1, 1'b0);
        end
        er = 2'b00;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
